// File: rtl/axi_mm2s_bridge_fifo.sv
//==============================================================================
// axi_mm2s_bridge_fifo : AXI4 write slave -> AXI4-Stream master through a FWFT FIFO
// Optional status outputs when AXI_MM2S_STATUS_EN is defined.  Rev 1.0
//==============================================================================
`default_nettype none

module axi_mm2s_bridge_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_FIFO_DEPTH       = 16,
  parameter int C_MAX_OUTSTANDING  = 8,
  parameter int C_TLAST_MODE       = 0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  // write address
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic [0:0]                        S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // write data / response
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // read address / data
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic [0:0]                        S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // stream out
  output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
`ifdef AXI_MM2S_STATUS_EN
  ,
  output logic [$clog2(C_FIFO_DEPTH):0]     STATUS_LEVEL,
  output logic [31:0]                       STATUS_BURSTS
`endif
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int EW     = DW + STRB_W + 1;
  localparam int CW     = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int PW     = $clog2(C_FIFO_DEPTH);

  localparam logic [CW-1:0] MAX_OUT = CW'(C_MAX_OUTSTANDING);
  localparam logic [PW:0]   DEPTH_L = (PW+1)'(C_FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Handshakes and burst bookkeeping
  // ---------------------------------------------------------------------------
  logic w_aw_hs, w_w_hs, w_wlast_hs, w_b_hs, w_pop;
  logic w_full, w_empty;

  logic [CW-1:0] out_q,   out_d;
  logic [CW-1:0] open_q,  open_d;
  logic [CW-1:0] bpend_q, bpend_d;

  assign S_AXI_AWREADY = (out_q < MAX_OUT);
  assign S_AXI_WREADY  = !w_full && (open_q != '0);
  assign S_AXI_BVALID  = (bpend_q != '0);
  assign S_AXI_BRESP   = 2'b00;

  assign w_aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign w_wlast_hs = w_w_hs && S_AXI_WLAST;
  assign w_b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign w_pop      = M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    out_d   = out_q;
    open_d  = open_q;
    bpend_d = bpend_q;
    if (w_aw_hs && !w_b_hs)      out_d = out_q + CW'(1);
    else if (!w_aw_hs && w_b_hs) out_d = out_q - CW'(1);
    if (w_aw_hs && !w_wlast_hs)      open_d = open_q + CW'(1);
    else if (!w_aw_hs && w_wlast_hs) open_d = open_q - CW'(1);
    if (w_wlast_hs && !w_b_hs)      bpend_d = bpend_q + CW'(1);
    else if (!w_wlast_hs && w_b_hs) bpend_d = bpend_q - CW'(1);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      out_q   <= '0;
      open_q  <= '0;
      bpend_q <= '0;
    end else begin
      out_q   <= out_d;
      open_q  <= open_d;
      bpend_q <= bpend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO; pointers carry one wrap bit
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [C_FIFO_DEPTH];
  logic [PW:0]   wr_q, rd_q, w_level;
  logic [EW-1:0] w_head;

  assign w_level = wr_q - rd_q;
  assign w_full  = (w_level == DEPTH_L);
  assign w_empty = (w_level == '0);
  assign w_head  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_w_hs) wr_q <= wr_q + (PW+1)'(1);
      if (w_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  // Storage is not reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_w_hs) mem_q[wr_q[PW-1:0]] <= {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
  end

  assign M_AXIS_TVALID = !w_empty;
  assign M_AXIS_TDATA  = w_empty ? '0 : w_head[EW-1 -: DW];
  assign M_AXIS_TKEEP  = w_empty ? '0 : w_head[STRB_W:1];

  generate
    if (C_TLAST_MODE == 1) begin : g_tlast_copy
      assign M_AXIS_TLAST = !w_empty && w_head[0];
    end else begin : g_tlast_zero
      assign M_AXIS_TLAST = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read responder: returns zero data for the requested number of beats
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  rd_state_e  rd_state_q, rd_state_d;
  logic [8:0] beats_q, beats_d;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RD_IDLE;
      beats_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      beats_q    <= beats_d;
    end
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    beats_d       = beats_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) begin
          beats_d    = {1'b0, S_AXI_ARLEN} + 9'd1;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = (beats_q == 9'd1);
        if (S_AXI_RREADY) begin
          beats_d = beats_q - 9'd1;
          if (beats_q == 9'd1) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign S_AXI_RDATA = '0;
  assign S_AXI_RRESP = 2'b00;

`ifdef AXI_MM2S_STATUS_EN
  logic [31:0] bursts_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) bursts_q <= '0;
    else if (w_b_hs)    bursts_q <= bursts_q + 32'd1;
  end

  assign STATUS_LEVEL  = w_level;
  assign STATUS_BURSTS = bursts_q;
`endif

  // Address-channel attributes only take part in the handshake.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                       S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST,
                       S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, w_head[0]};

endmodule

`default_nettype wire

// File: doc/axi_mm2s_bridge_fifo.md
# axi_mm2s_bridge_fifo

Parametrised AXI4-Full write-slave to AXI4-Stream master bridge. It succeeds the fixed 128-bit register-slice bridge with a configurable-width, configurable-depth FIFO, strict AW/W burst pairing and a bounded outstanding-burst budget. It adds selectable TLAST generation and a burst-correct read responder. It sits between the PS/interconnect master port and instruction/data stream consumers in the PL.

## Interface
- C_S_AXI_DATA_WIDTH, 128, data width in bits; one of 32/64/128/256/512.
- C_S_AXI_ADDR_WIDTH, 32, address width; address is accepted but ignored.
- C_FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- C_MAX_OUTSTANDING, 8, maximum bursts with AW accepted and B not yet handshaken; 1..255.
- C_TLAST_MODE, 0, 0 = TLAST always 0; 1 = TLAST copies the stored WLAST.
- S_AXI_ACLK in 1: the single clock.
- S_AXI_ARESETN in 1: reset, asynchronous assert, active-low.
- S_AXI_AW{ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT} in std: captured only for the handshake; contents ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write-address handshake.
- S_AXI_WDATA in DW: write data.
- S_AXI_WSTRB in DW/8: write strobes.
- S_AXI_WLAST in 1: last beat of a write burst.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write-data handshake.
- S_AXI_BRESP out 2: always 2'b00.
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write-response handshake.
- S_AXI_AR{ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT} in std, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read-address channel.
- S_AXI_RDATA out DW, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read-data channel.
- M_AXIS_TDATA out DW, M_AXIS_TKEEP out DW/8, M_AXIS_TLAST out 1, M_AXIS_TVALID out 1, M_AXIS_TREADY in 1: stream output.

## Operation
- Counters:
  - outstanding: AW accepted minus B handshaken.
  - open: AW accepted minus WLAST accepted.
  - b_pend: WLAST accepted minus B handshaken.
  - All counters are clog2(C_MAX_OUTSTANDING+1) bits wide.
- S_AXI_AWREADY = (outstanding < C_MAX_OUTSTANDING).
- S_AXI_WREADY = !full && (open > 0). A W beat is never accepted before its AW.
- W handshake pushes {WDATA, WSTRB, WLAST} into the FIFO.
- S_AXI_BVALID = (b_pend > 0); BRESP is always OKAY.
- Simultaneous increment and decrement on any counter leaves it unchanged.
- FIFO is first-word-fall-through:
  - M_AXIS_TVALID = !empty.
  - M_AXIS_TDATA / TKEEP are the head entry; TKEEP = stored WSTRB, unmodified.
  - Pop on TVALID && TREADY.
- Full is evaluated before the pop, so no push occurs while full even if a pop happens the same cycle. This costs at most one bubble per full event.
- Read responder, two states:
  - IDLE: ARREADY=1. An AR handshake latches beats=ARLEN+1 and moves to BURST.
  - BURST: ARREADY=0, RVALID=1, RDATA=0, RRESP=OKAY, RLAST=(beats==1). Each R handshake decrements beats; the final one returns to IDLE.
- Reset (asynchronous, any time): FIFO flushed, all counters zeroed, read FSM to IDLE. In-flight bursts are dropped with no B issued.

## Timing
- Values while S_AXI_ARESETN is low: AWREADY=1, WREADY=0, BVALID=0, ARREADY=1, RVALID=0, RLAST=0, TVALID=0, TDATA=0, TKEEP=0, TLAST=0.
- W-to-stream latency: beat accepted at edge N gives TVALID=1 after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained while TREADY=1 and an AW is open.
- AW-to-WREADY: AW accepted at edge N lets WREADY rise in cycle N+1.
- WLAST-to-BVALID: WLAST accepted at edge N gives BVALID=1 in cycle N+1.
- AR-to-first-R: AR accepted at edge N gives RVALID=1 in cycle N+1.
- TVALID and the B/R valids never drop without a handshake.

## Configuration
- AXI_MM2S_STATUS_EN defined:
  - Adds output STATUS_LEVEL [clog2(C_FIFO_DEPTH):0], the current FIFO occupancy.
  - Adds output STATUS_BURSTS [31:0], a wrapping count of B handshakes.
  - Both reset to 0.
- Undefined: neither port nor its logic exists.

## Test plan
- Reset mid-burst: AWLEN=3 accepted, 2 beats in, reset asserted → FIFO empty, TVALID=0, BVALID=0, no B issued after release.
- W before AW: WVALID=1 with data 0xA5, no AW → WREADY=0. AW accepted at edge N → WREADY=1 in N+1, TDATA=0xA5 with TVALID in N+2.
- Backpressure fill: C_FIFO_DEPTH=4, AWLEN=7, TREADY=0 → WREADY drops after 4 beats. TREADY=1 → all 8 beats emerge in order, TKEEP=WSTRB, one B after beat 8 is accepted.
- Outstanding limit: C_MAX_OUTSTANDING=2, BREADY=0, three single-beat bursts → third AWREADY=0. BREADY=1 for one B → third AW accepted next cycle.
- TLAST mode: C_TLAST_MODE=1, AWLEN=1 → TLAST=0,1. C_TLAST_MODE=0 → TLAST=0,0.
- Read burst: ARLEN=3 → exactly 4 R beats, RDATA=0, RRESP=0, RLAST only on the 4th beat, ARREADY=0 throughout.
